phase_diff_meas: RTL and testbench
==================================

// Module: phase_diff_meas
// PURPOSE
//   Downstream of the per-channel DC-midpoint stage; consumes data_in0/1 and their midpoints mid0/mid1.
//   Squares both channels against their midpoints and detects rising crossings.
//   Measures the ch0 period and the ch0->ch1 rise delay in clk cycles.
//   Publishes one result pair per ch0 period for the phase-angle calculation.
// PARAMETERS
//   DW       12          sample and midpoint width
//   CW       32          period/delay counter width
//   HYST     8           hysteresis half-band, in LSB; used only when PHASE_HYST_EN is defined
//   TIMEOUT  10_000_000  max cycles without a ch0 rise (100 ms at 100 MHz)
// PORTS
//   clk         in   1   100 MHz clock
//   rst         in   1   asynchronous, active-low reset
//   data_in0    in   DW  channel 0 sample, unsigned
//   data_in1    in   DW  channel 1 sample, unsigned
//   mid0        in   DW  channel 0 midpoint
//   mid1        in   DW  channel 1 midpoint
//   mid_valid   in   1   midpoints are valid (level)
//   period_cnt  out  CW  last ch0 period, in clk cycles
//   delay_cnt   out  CW  last ch0-rise to ch1-rise delay, in clk cycles
//   meas_valid  out  1   1-cycle pulse when period_cnt/delay_cnt update
//   timeout_err out  1   sticky; cleared by the next meas_valid or by reset
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters 0, squared signals 0.
//   Pipeline: samples registered (1 cycle), then sq registered (1 cycle).
//     rise = sq & ~sq_d. A crossing is seen 2 cycles after the sample.
//   Squaring (no hysteresis): sq = (data > mid). Compare at DW bits.
//   FSM states IDLE, ARM, RUN:
//     IDLE: cnt held at 0. When mid_valid=1, go to ARM.
//     ARM: wait for rise0. On rise0: cnt<=0, seen1<=0, go to RUN.
//          If rise1 occurs in the same cycle: delay_r<=0, seen1<=1.
//     RUN: cnt increments each cycle and saturates at 2^CW-1.
//          First rise1 with seen1=0: delay_r<=cnt, seen1<=1. Later rise1s are ignored.
//          rise0 with seen1=1: period_cnt<=cnt, delay_cnt<=delay_r, meas_valid=1 next cycle,
//            timeout_err<=0, cnt<=0. Stay in RUN (back-to-back measurements).
//          rise0 with seen1=0: no output; cnt<=0, restart the period.
//          rise0 and rise1 in the same cycle: close the current period using the old seen1,
//            then start the new period with delay_r<=0, seen1<=1.
//          cnt==TIMEOUT-1: timeout_err<=1, go to ARM. Outputs hold their last values.
//   mid_valid=0 in any state: go to IDLE next cycle; outputs hold; timeout_err holds.
//   Reset mid-measurement discards the partial period; no meas_valid is issued.
// CONFIGURATION
//   PHASE_HYST_EN defined:
//     sq sets when data >= mid+HYST and clears when data <= mid-HYST; otherwise sq holds.
//     Thresholds are computed at DW+1 bits and clamped to [0, 2^DW-1].
//   PHASE_HYST_EN undefined: plain comparison (sq = data > mid); HYST is unused.
// STRUCTURE
//   phase_pkg: FSM state localparams (IDLE/ARM/RUN), default DW/CW, TIMEOUT_100MS.
//   Sub-module zc_detect (sample reg, squarer with optional hysteresis, rise edge).
//     Instantiated once per channel.
//   Top level: FSM, cnt, delay_r/seen1, output registers.
// TESTING
//   1. mid=2048; ch0 and ch1 square waves of period 1000 clk, ch1 lagging 250 clk
//      -> meas_valid every 1000 clk with period_cnt=1000, delay_cnt=250.
//   2. ch1 in phase with ch0 (simultaneous rises) -> delay_cnt=0, period_cnt=1000.
//   3. ch0 held constant after 2 periods, TIMEOUT set to 5000 for the test
//      -> timeout_err=1 at 5000 cycles after the last rise0;
//      a restarted waveform gives the next meas_valid and clears timeout_err.
//   4. ch1 held flat -> no meas_valid; cnt restarts on each rise0; no timeout while ch0 toggles.
//   5. PHASE_HYST_EN, HYST=8, ch0 = sine around 2048 plus +/-5 LSB noise at each crossing
//      -> exactly one rise0 per period, period_cnt stable within +/-1.
//   6. Drop mid_valid mid-period, then reset mid-RUN -> IDLE, no spurious pulse;
//      outputs are 0 after reset.

Source files
------------

// File: rtl/phase_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_pkg: shared state encoding and defaults for the phase-difference      |
// | meter.                                                                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package phase_pkg;

    localparam int unsigned DW_DEF        = 12;
    localparam int unsigned CW_DEF        = 32;
    localparam int unsigned HYST_DEF      = 8;
    localparam int unsigned TIMEOUT_100MS = 10_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/zc_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | zc_detect: sample register, squarer against the channel midpoint and        |
// | rising-crossing strobe. PHASE_HYST_EN selects the hysteresis squarer.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module zc_detect
    import phase_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned HYST = HYST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in,
    input  logic [DW-1:0] mid,
    output logic          rise
);

    logic [DW-1:0] sample;
    logic          sq;
    logic          sq_d;
    logic          sq_next;

`ifdef PHASE_HYST_EN
    localparam logic [DW:0] MAX_V  = {1'b0, {DW{1'b1}}};
    localparam logic [DW:0] HYST_X = (DW+1)'(HYST);

    logic [DW:0] mid_x;
    logic [DW:0] hi_raw;
    logic [DW:0] hi_th;
    logic [DW:0] lo_th;

    // Thresholds live one bit wider so mid+HYST / mid-HYST can be clamped.
    always_comb begin
        mid_x   = {1'b0, mid};
        hi_raw  = mid_x + HYST_X;
        hi_th   = (hi_raw > MAX_V) ? MAX_V : hi_raw;
        lo_th   = (mid_x < HYST_X) ? '0 : (mid_x - HYST_X);
        sq_next = sq;
        if ({1'b0, sample} >= hi_th) begin
            sq_next = 1'b1;
        end else if ({1'b0, sample} <= lo_th) begin
            sq_next = 1'b0;
        end
    end
`else
    always_comb begin
        sq_next = (sample > mid);
    end

    if (HYST > 0) begin : g_hyst_unused
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample <= '0;
            sq     <= 1'b0;
            sq_d   <= 1'b0;
        end else begin
            sample <= data_in;
            sq     <= sq_next;
            sq_d   <= sq;
        end
    end

    assign rise = sq & ~sq_d;

endmodule
`default_nettype wire

// File: rtl/phase_diff_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_diff_meas: measures the ch0 period and the ch0->ch1 rise delay in     |
// | clk cycles. Optional hysteresis squaring via PHASE_HYST_EN.                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module phase_diff_meas
    import phase_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned HYST    = HYST_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_100MS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] mid0,
    input  logic [DW-1:0] mid1,
    input  logic          mid_valid,
    output logic [CW-1:0] period_cnt,
    output logic [CW-1:0] delay_cnt,
    output logic          meas_valid,
    output logic          timeout_err
);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic          rise0;
    logic          rise1;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] delay_r;
    logic          seen1;
    logic          start;
    logic          close;
    logic          grab1;
    logic          tmo;

    zc_detect #(.DW(DW), .HYST(HYST)) u_zc0 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in0),
        .mid     (mid0),
        .rise    (rise0)
    );

    zc_detect #(.DW(DW), .HYST(HYST)) u_zc1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in1),
        .mid     (mid1),
        .rise    (rise1)
    );

    // cnt reads 0 in the cycle after a rise0, so cnt+1 is the elapsed cycle count.
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : (cnt + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        close      = 1'b0;
        grab1      = 1'b0;
        tmo        = 1'b0;
        if (!mid_valid) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_ARM;
                ST_ARM: begin
                    if (rise0) begin
                        start      = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rise0) begin
                        start = 1'b1;
                        close = seen1;
                    end else begin
                        grab1 = rise1 & ~seen1;
                        if (cnt == TMO_LAST) begin
                            tmo        = 1'b1;
                            state_next = ST_ARM;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            delay_r     <= '0;
            seen1       <= 1'b0;
            period_cnt  <= '0;
            delay_cnt   <= '0;
            meas_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            meas_valid <= close;
            if (close) begin
                period_cnt  <= cnt_inc;
                delay_cnt   <= delay_r;
                timeout_err <= 1'b0;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
            // A rise1 coinciding with the opening rise0 belongs to the new period.
            if (start) begin
                cnt   <= '0;
                seen1 <= rise1;
                if (rise1) begin
                    delay_r <= '0;
                end
            end else if (state_next == ST_RUN) begin
                cnt <= cnt_inc;
                if (grab1) begin
                    delay_r <= cnt_inc;
                    seen1   <= 1'b1;
                end
            end else begin
                cnt   <= '0;
                seen1 <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_diff_meas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_phase_diff_meas: directed vector table plus hand-written sequences for   |
// | timeout, mid_valid drop, reset and (with PHASE_HYST_EN) noisy sine input.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_phase_diff_meas;

    localparam logic [11:0] LO  = 12'd1000;
    localparam logic [11:0] HI  = 12'd3000;
    localparam logic [11:0] MID = 12'd2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] data_in0 = LO;
    logic [11:0] data_in1 = LO;
    logic        mid_valid = 1'b0;
    logic [31:0] period_cnt;
    logic [31:0] delay_cnt;
    logic        meas_valid;
    logic        timeout_err;

    phase_diff_meas #(.DW(12), .CW(32), .HYST(8), .TIMEOUT(5000)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in0    (data_in0),
        .data_in1    (data_in1),
        .mid0        (MID),
        .mid1        (MID),
        .mid_valid   (mid_valid),
        .period_cnt  (period_cnt),
        .delay_cnt   (delay_cnt),
        .meas_valid  (meas_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int t = 0;
    int per = 1000;
    int lag = 250;
    bit ch0_on = 1'b0;
    bit ch1_on = 1'b0;
    bit sine_mode = 1'b0;
    int pulses = 0;
    bit chk_pulse = 1'b0;
    int exp_per = 0;
    int exp_dly = 0;
    int tol = 0;
    bit tmo_seen = 1'b0;
    int tmo_t = 0;

    typedef struct {
        int per;
        int lag;
        bit ch1_on;
        int cycles;
        int exp_n;
        int exp_per;
        int exp_dly;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp, input int tl);
        checks++;
        if (act < exp - tl || act > exp + tl) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at t=%0d", name, act, exp, tl, t);
        end
    endtask

    function automatic logic [11:0] level(input int ph);
        real a;
        int  v;
        if (sine_mode) begin
            a = 6.283185307 * real'(ph) / real'(per);
            v = 2048 + $rtoi(1000.0 * $sin(a));
            if (v > 2040 && v < 2056) begin
                v = v + int'($urandom_range(10)) - 5;
            end
            return 12'(v);
        end
        return (ph >= per / 2) ? HI : LO;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (meas_valid) begin
            pulses++;
            if (chk_pulse) begin
                chk("period_cnt", int'(period_cnt), exp_per, tol);
                chk("delay_cnt", int'(delay_cnt), exp_dly, tol);
            end
        end
        if (timeout_err && !tmo_seen) begin
            tmo_seen = 1'b1;
            tmo_t    = t;
        end
        data_in0 = ch0_on ? level(t % per) : LO;
        data_in1 = ch1_on ? level((t + per - lag) % per) : LO;
        t++;
    endtask

    task automatic run_to(input int t_end);
        while (t < t_end) step();
    endtask

    // Flush the front end with low samples through IDLE, then start at t=0.
    task automatic restart(input int p, input int l, input bit c1);
        mid_valid = 1'b0;
        ch0_on    = 1'b0;
        ch1_on    = 1'b0;
        for (int i = 0; i < 6; i++) step();
        per       = p;
        lag       = l;
        t         = 0;
        pulses    = 0;
        tmo_seen  = 1'b0;
        mid_valid = 1'b1;
        ch0_on    = 1'b1;
        ch1_on    = c1;
    endtask

    initial begin
        vecs[0] = '{1000, 250, 1'b1, 5400, 4, 1000, 250};
        vecs[1] = '{1000,   0, 1'b1, 5400, 4, 1000,   0};
        vecs[2] = '{ 600, 150, 1'b1, 3400, 5,  600, 150};
        vecs[3] = '{1000, 999, 1'b1, 5400, 4, 1000, 999};
        vecs[4] = '{1000,   1, 1'b1, 5400, 4, 1000,   1};
        vecs[5] = '{1000,   0, 1'b0, 5400, 0, 1000,   0};

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("reset period_cnt", int'(period_cnt), 0, 0);
        chk("reset delay_cnt", int'(delay_cnt), 0, 0);
        chk("reset meas_valid", int'(meas_valid), 0, 0);
        chk("reset timeout_err", int'(timeout_err), 0, 0);
        rst = 1'b1;

        // Steady-state measurements, in-phase, lags at the edges, flat ch1
        chk_pulse = 1'b1;
        tol       = 0;
        for (int v = 0; v < 6; v++) begin
            exp_per = vecs[v].exp_per;
            exp_dly = vecs[v].exp_dly;
            restart(vecs[v].per, vecs[v].lag, vecs[v].ch1_on);
            run_to(vecs[v].cycles);
            chk("pulse count", pulses, vecs[v].exp_n, 0);
            chk("no timeout", int'(timeout_err), 0, 0);
        end

        // Timeout after ch0 stops, then recovery
        exp_per = 1000;
        exp_dly = 250;
        restart(1000, 250, 1'b1);
        run_to(2600);
        ch0_on = 1'b0;
        run_to(7600);
        chk("pulses before timeout", pulses, 2, 0);
        chk("timeout seen", int'(tmo_seen), 1, 0);
        chk("timeout cycle", tmo_t, 7503, 0);
        chk("period holds", int'(period_cnt), 1000, 0);
        run_to(8000);
        ch0_on = 1'b1;
        run_to(9000);
        chk("timeout sticky", int'(timeout_err), 1, 0);
        run_to(9600);
        chk("pulses after recovery", pulses, 3, 0);
        chk("timeout cleared", int'(timeout_err), 0, 0);

        // mid_valid drop mid-period, then reset mid-RUN
        restart(1000, 250, 1'b1);
        run_to(2000);
        chk("pulse before drop", pulses, 1, 0);
        mid_valid = 1'b0;
        run_to(2100);
        mid_valid = 1'b1;
        run_to(3200);
        chk("no pulse after drop", pulses, 1, 0);
        chk("period holds after drop", int'(period_cnt), 1000, 0);
        rst = 1'b0;
        run_to(3203);
        chk("mid-run reset period_cnt", int'(period_cnt), 0, 0);
        chk("mid-run reset delay_cnt", int'(delay_cnt), 0, 0);
        rst = 1'b1;
        run_to(3600);
        chk("no pulse after reset", pulses, 1, 0);
        chk("period_cnt after reset", int'(period_cnt), 0, 0);
        chk("meas_valid after reset", int'(meas_valid), 0, 0);

`ifdef PHASE_HYST_EN
        // Noisy sine: one rise per period thanks to hysteresis
        sine_mode = 1'b1;
        tol       = 1;
        exp_per   = 1000;
        exp_dly   = 250;
        restart(1000, 250, 1'b1);
        run_to(5400);
        chk("sine pulse count", pulses, 5, 0);
        chk("sine no timeout", int'(timeout_err), 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
